// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample framer: default sizes, the
// per-bank occupancy flag and the launch FSM state encoding.
// No ports; imported by fft_frame_bank and fft_sample_framer.
package fft_pkg;

  localparam int FFT_SAMPLES = 16;
  localparam int FFT_WIDTH   = 32;

  // Occupancy of one ping-pong bank.
  typedef enum logic [1:0] {
    BANK_EMPTY  = 2'd0,
    BANK_FULL   = 2'd1,
    BANK_ACTIVE = 2'd2
  } bank_flag_t;

  // Launch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } launch_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: SAMPLES words written one at a time, all read in parallel.
// Ports: clk, rst_n (async active-low), wr_en/wr_idx/wr_data write port,
//        rd_data parallel view of the whole bank (combinational).
module fft_frame_bank #(
  parameter int SAMPLES = 16,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(SAMPLES)-1:0] wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data [SAMPLES]
);

  logic [WIDTH-1:0] mem [SAMPLES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SAMPLES; k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < SAMPLES; k++) rd_data[k] = mem[k];
  end

endmodule

// File: rtl/fft_sample_framer.sv
// Collects a sample stream into ping-pong frame banks and launches an FFT
// per full frame, strictly in fill order, holding the frame until fft_done.
// Ports: clk, rst_n (async active-low); in_sample/in_valid/in_ready stream
//        input; frame_out parallel frame, fft_start launch pulse, fft_done
//        consume strobe, busy (launch in progress), frame_cnt (wrapping).
module fft_sample_framer
  import fft_pkg::*;
#(
  parameter int SAMPLES = FFT_SAMPLES,
  parameter int WIDTH   = FFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame_out [SAMPLES],
  output logic             fft_start,
  input  logic             fft_done,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int IDXW = $clog2(SAMPLES);

  bank_flag_t        flag_q [2];
  logic              fill_q;     // bank currently being written
  logic              launch_q;   // oldest bank not yet launched
  logic              active_q;   // bank owned by the running FFT
  logic [IDXW-1:0]   wr_idx_q;
  launch_state_t     state_q, state_d;
  logic [WIDTH-1:0]  rd0 [SAMPLES];
  logic [WIDTH-1:0]  rd1 [SAMPLES];
  logic              accept, last_accept;

  // Ready depends only on registered flags, never on in_valid.
  assign in_ready    = (flag_q[fill_q] == BANK_EMPTY);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (wr_idx_q == IDXW'(SAMPLES - 1));

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && !fill_q),
    .wr_idx  (wr_idx_q),
    .wr_data (in_sample),
    .rd_data (rd0)
  );

  fft_frame_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && fill_q),
    .wr_idx  (wr_idx_q),
    .wr_data (in_sample),
    .rd_data (rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fft_start = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flag_q[launch_q] == BANK_FULL) state_d = ST_START;
      end
      ST_START: begin
        fft_start = 1'b1;
        busy      = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (fft_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) flag_q[b] <= BANK_EMPTY;
      fill_q    <= 1'b0;
      launch_q  <= 1'b0;
      active_q  <= 1'b0;
      wr_idx_q  <= '0;
      frame_cnt <= '0;
      for (int k = 0; k < SAMPLES; k++) frame_out[k] <= '0;
    end else begin
      // The three flag updates always target different banks: the fill
      // bank is EMPTY, the launching bank FULL and the running bank ACTIVE.
      for (int b = 0; b < 2; b++) begin
        if (state_q == ST_WAIT && fft_done && active_q == 1'(b))
          flag_q[b] <= BANK_EMPTY;
        if (state_q == ST_START && launch_q == 1'(b))
          flag_q[b] <= BANK_ACTIVE;
        if (last_accept && fill_q == 1'(b))
          flag_q[b] <= BANK_FULL;
      end

      if (accept) begin
        wr_idx_q <= wr_idx_q + IDXW'(1);
        if (last_accept) fill_q <= ~fill_q;
      end

      // Copy the frame out on selection so it stays put while the bank
      // itself is freed and refilled.
      if (state_q == ST_IDLE && state_d == ST_START) begin
        for (int k = 0; k < SAMPLES; k++)
          frame_out[k] <= launch_q ? rd1[k] : rd0[k];
      end

      if (state_q == ST_START) begin
        active_q  <= launch_q;
        launch_q  <= ~launch_q;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_sample_framer.sv
// Self-checking bench for fft_sample_framer: vector table, directed corner
// sequences and randomized traffic, all compared against a frame-queue model.
module tb_fft_sample_framer;

  localparam int N = 16;
  localparam int W = 32;

  typedef logic [N-1:0][W-1:0] frame_t;

  typedef struct {
    logic        v;
    logic [31:0] s;
    logic        d;
    logic        e_rdy;
    logic        e_start;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_sample;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] frame_out [N];
  logic         fft_start;
  logic         fft_done;
  logic         busy;
  logic [15:0]  frame_cnt;

  int nchk = 0;
  int nerr = 0;

  // Reference model: frames as whole values moving through queues.
  frame_t      pend_q [$];  // complete frames not yet launched, fill order
  frame_t      part;
  int          part_n;
  frame_t      m_out;
  logic [15:0] m_cnt;
  int          m_phase;     // 0 idle, 1 launch pulse, 2 fft running

  vec_t tbl [22];

  fft_sample_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frame_out (frame_out),
    .fft_start (fft_start),
    .fft_done  (fft_done),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    int nonempty;
    nonempty = pend_q.size() + ((m_phase != 0) ? 1 : 0);
    return nonempty < 2;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    part    = '0;
    part_n  = 0;
    m_out   = '0;
    m_cnt   = '0;
    m_phase = 0;
  endtask

  // One clock edge of the model, using the inputs presented before it.
  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    case (m_phase)
      0: if (pend_q.size() > 0) begin
        m_out   = pend_q.pop_front();
        m_phase = 1;
      end
      1: begin
        m_cnt   = m_cnt + 16'd1;
        m_phase = 2;
      end
      default: if (fft_done) m_phase = 0;
    endcase
    if (in_valid && rdy) begin
      part[part_n] = in_sample;
      part_n++;
      if (part_n == N) begin
        pend_q.push_back(part);
        part_n = 0;
      end
    end
  endtask

  task automatic compare_all();
    int bad;
    bad = -1;
    check("in_ready", 64'(in_ready), 64'(model_ready()));
    check("fft_start", 64'(fft_start), 64'(m_phase == 1));
    check("busy", 64'(busy), 64'(m_phase != 0));
    check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    for (int k = 0; k < N; k++)
      if (bad < 0 && frame_out[k] !== m_out[k]) bad = k;
    if (bad < 0) bad = 0;
    check($sformatf("frame_out[%0d]", bad), 64'(frame_out[bad]), 64'(m_out[bad]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_checks();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fft_start", 64'(fft_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    for (int k = 0; k < N; k += 5)
      check($sformatf("rst_frame_out[%0d]", k), 64'(frame_out[k]), 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic apply_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    fft_done = 1'b0;
    #1;
    model_clear();
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] s);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_sample = s;
    while (!in_ready && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) begin
      nchk++;
      nerr++;
      $display("FAIL push_timeout: in_ready low for %0d cycles, required 1 within 64", t);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic steps_to_start(output int n);
    n = 0;
    while (fft_start !== 1'b1 && n < 8) begin
      step();
      n++;
    end
  endtask

  function automatic logic [31:0] f2(input int k);
    return 32'(900) - 32'(100 * k);
  endfunction

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    fft_done  = 1'b0;
    model_clear();
    #3;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0,100,...,1500 then consume it.
    for (int i = 0; i < 22; i++) begin
      tbl[i].v       = (i < 16);
      tbl[i].s       = (i < 16) ? 32'(100 * i) : 32'd0;
      tbl[i].d       = (i == 20);
      tbl[i].e_rdy   = 1'b1;
      tbl[i].e_start = (i == 16);
      tbl[i].e_busy  = (i >= 16 && i < 20);
      tbl[i].e_cnt   = (i >= 17) ? 16'd1 : 16'd0;
    end
    for (int i = 0; i < 22; i++) begin
      in_valid  = tbl[i].v;
      in_sample = tbl[i].s;
      fft_done  = tbl[i].d;
      step();
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("vec%0d_fft_start", i), 64'(fft_start), 64'(tbl[i].e_start));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      check($sformatf("vec%0d_frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].e_cnt));
      if (i == 16)
        for (int k = 0; k < N; k++)
          check($sformatf("vec_frame_out[%0d]", k), 64'(frame_out[k]), 64'(100 * k));
    end
    in_valid = 1'b0;
    fft_done = 1'b0;

    // Two frames with fft_done withheld: backpressure, held sample.
    apply_reset();
    for (int k = 0; k < N; k++) push(32'(100 * k));
    for (int k = 0; k < N; k++) push(f2(k));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b1;
    in_sample = 32'd7777;
    repeat (5) step();
    check("bp_held_in_ready", 64'(in_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("bp_ready_after_done", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_frame2_start", 64'(fft_start), 64'd1);
    for (int k = 0; k < N; k += 3)
      check($sformatf("bp_frame2[%0d]", k), 64'(frame_out[k]), 64'(f2(k)));
    step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    for (int k = 1; k < N; k++) push(32'(5000 + k));
    steps_to_start(n);
    check("bp_frame3_delay", 64'(n), 64'd1);
    check("bp_frame3_first", 64'(frame_out[0]), 64'd7777);

    // fft_done while idle and during the launch pulse is ignored.
    apply_reset();
    fft_done = 1'b1;
    step();
    step();
    fft_done = 1'b0;
    check("done_idle_busy", 64'(busy), 64'd0);
    for (int k = 0; k < N; k++) push(32'(k + 1));
    steps_to_start(n);
    check("done_idle_delay", 64'(n), 64'd1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("done_start_busy", 64'(busy), 64'd1);
    repeat (3) step();
    check("done_start_still_busy", 64'(busy), 64'd1);
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("done_wait_busy", 64'(busy), 64'd0);

    // Last sample of frame 2 on the same edge frame 1 completes.
    apply_reset();
    for (int k = 0; k < N; k++) push(32'(10 + k));
    for (int k = 0; k < N - 1; k++) push(32'(200 + k));
    in_valid  = 1'b1;
    in_sample = 32'(200 + N - 1);
    fft_done  = 1'b1;
    step();
    in_valid = 1'b0;
    fft_done = 1'b0;
    check("same_edge_busy", 64'(busy), 64'd0);
    check("same_edge_in_ready", 64'(in_ready), 64'd1);
    steps_to_start(n);
    check("same_edge_delay", 64'(n), 64'd1);
    for (int k = 0; k < N; k += 4)
      check($sformatf("same_edge_frame[%0d]", k), 64'(frame_out[k]), 64'(200 + k));

    // Reset mid-fill and mid-FFT.
    apply_reset();
    for (int k = 0; k < 7; k++) push(32'(k + 40));
    apply_reset();
    for (int k = 0; k < N; k++) push(32'(k + 60));
    steps_to_start(n);
    step();
    check("rst_fill_cnt", 64'(frame_cnt), 64'd1);
    check("rst_fill_frame0", 64'(frame_out[0]), 64'd60);
    step();
    apply_reset();
    for (int k = 0; k < N; k++) push(32'(k + 80));
    steps_to_start(n);
    step();
    check("rst_wait_cnt", 64'(frame_cnt), 64'd1);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sample = $urandom;
      fft_done  = ($urandom_range(0, 7) == 0);
      step();
    end

    // Saturating load with immediate completion.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'b1;
      in_sample = $urandom;
      fft_done  = 1'b1;
      step();
    end
    in_valid = 1'b0;
    fft_done = 1'b0;
    check("load_frame_cnt", 64'(frame_cnt), 64'(m_cnt));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
